scroll_window: RTL and testbench

- Downstream consumer of the message BRAM's read port.
- Walks the stored nibble message at a fixed step rate and shifts each nibble into a 32-bit, 8-digit display window.
- The window feeds the eight hex_to_sseg decoders and disp_mux.
- Replaces the free-running shift/counter chain with a controlled read FSM: start, pause, programmable message length and wrap-around.

---
 rtl/scroll_pkg.sv | 9 +
 rtl/scroll_window_if.sv | 28 ++
 rtl/step_prescaler.sv | 26 ++
 rtl/scroll_window.sv | 88 ++++++++
 tb/tb_scroll_window.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/scroll_pkg.sv
// Shared types and default geometry for the scrolling message window.
package scroll_pkg;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned WIN_W  = DIGITS * DATA_W;

  typedef enum logic [1:0] {IDLE, WAIT_STEP, READ, SHIFT} scroll_state_t;
endpackage

// File: rtl/scroll_window_if.sv
// Control, BRAM read port and display signals of the scroll window.
interface scroll_window_if
  import scroll_pkg::*;
#(
  parameter int unsigned ADDR_W = scroll_pkg::ADDR_W,
  parameter int unsigned DATA_W = scroll_pkg::DATA_W,
  parameter int unsigned DIGITS = scroll_pkg::DIGITS
);
  logic                       start;
  logic                       en;
  logic [ADDR_W-1:0]          msg_len;
  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic [DIGITS*DATA_W-1:0]   window;
  logic                       shifted;
  logic                       wrap;

  modport master (
    output start, en, msg_len, rd_data,
    input  rd_en, rd_addr, window, shifted, wrap
  );

  modport slave (
    input  start, en, msg_len, rd_data,
    output rd_en, rd_addr, window, shifted, wrap
  );
endinterface

// File: rtl/step_prescaler.sv
// Mod-STEP_M step counter with clear and enable; tc_c marks the enabled terminal cycle.
module step_prescaler #(
  parameter int unsigned STEP_M = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc_c
);
  localparam int unsigned CNT_W = (STEP_M > 1) ? $clog2(STEP_M) : 1;

  logic [CNT_W-1:0] count;

  assign tc_c = en && (count == CNT_W'(STEP_M - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc_c ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/scroll_window.sv
// Steps through the nibble message in BRAM and shifts each nibble into the display window.
module scroll_window
  import scroll_pkg::*;
#(
  parameter int unsigned ADDR_W = scroll_pkg::ADDR_W,
  parameter int unsigned DATA_W = scroll_pkg::DATA_W,
  parameter int unsigned DIGITS = scroll_pkg::DIGITS,
  parameter int unsigned STEP_M = 100000000
) (
  input logic            clk,
  input logic            reset,
  scroll_window_if.slave bus
);
  localparam int unsigned WIN_BITS = DIGITS * DATA_W;

  scroll_state_t         state, state_nxt;
  logic [ADDR_W-1:0]     ptr;
  logic [WIN_BITS-1:0]   window_q;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic                  rd_en_q, shifted_q, wrap_q;
  logic                  tc_c;
  logic                  rd_en_nxt, shift_c, wrap_c;

  // Prescaler runs in every active state so steps stay STEP_M cycles apart.
  step_prescaler #(.STEP_M(STEP_M)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (bus.start),
    .en    (bus.en && (state != IDLE)),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; start overrides everything and drops any read in flight.
  always_comb begin
    state_nxt = state;
    rd_en_nxt = 1'b0;
    shift_c   = 1'b0;
    wrap_c    = 1'b0;
    case (state)
      IDLE:      state_nxt = IDLE;
      WAIT_STEP: if (tc_c) state_nxt = READ;
      READ:      state_nxt = SHIFT;
      SHIFT:     state_nxt = WAIT_STEP;
      default:   state_nxt = IDLE;
    endcase
    if (bus.start) begin
      state_nxt = WAIT_STEP;
    end else if (state == SHIFT) begin
      shift_c = 1'b1;
      wrap_c  = (ptr >= bus.msg_len);
    end
    rd_en_nxt = (state_nxt == READ);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      window_q  <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      shifted_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      rd_en_q   <= rd_en_nxt;
      shifted_q <= shift_c;
      wrap_q    <= wrap_c;
      if (rd_en_nxt) rd_addr_q <= ptr;
      if (bus.start) begin
        window_q <= '0;
        ptr      <= '0;
      end else if (shift_c) begin
        window_q <= {window_q[WIN_BITS-DATA_W-1:0], bus.rd_data};
        ptr      <= wrap_c ? '0 : ptr + 1'b1;
      end
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.window  = window_q;
  assign bus.shifted = shifted_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_scroll_window.sv
// Directed bench for scroll_window with a step-level reference model and a 1-cycle BRAM.
module tb_scroll_window;
  import scroll_pkg::*;

  localparam int STEP_M = 4;
  localparam int P_IDLE = 0, P_WAIT = 1, P_READ = 2, P_SHIFT = 3;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] ram_q = '0;
  int vectors = 0;
  int errors  = 0;

  scroll_window_if bus ();

  scroll_window #(.STEP_M(STEP_M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Message content: address a holds (a+1) mod 16, so addr0..3 = 1,2,3,4.
  function automatic logic [3:0] nib(input int a);
    return 4'((a + 1) % 16);
  endfunction

  always @(posedge clk) if (bus.rd_en) ram_q <= nib(int'(bus.rd_addr));
  assign bus.rd_data = ram_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a step happens after STEP_M enabled cycles; read, then shift.
  int          m_phase = P_IDLE;
  int          m_cnt = 0, m_ptr = 0, m_addr = 0;
  logic [31:0] m_win = '0;
  logic        m_rd_en = 1'b0, m_shifted = 1'b0, m_wrap = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = P_IDLE; m_cnt = 0; m_ptr = 0; m_addr = 0; m_win = '0;
      m_rd_en = 1'b0; m_shifted = 1'b0; m_wrap = 1'b0;
    end else if (bus.start) begin
      m_phase = P_WAIT; m_cnt = 0; m_ptr = 0; m_win = '0;
      m_rd_en = 1'b0; m_shifted = 1'b0; m_wrap = 1'b0;
    end else begin
      m_rd_en = 1'b0; m_shifted = 1'b0; m_wrap = 1'b0;
      if (m_phase != P_IDLE && bus.en) m_cnt = m_cnt + 1;
      case (m_phase)
        P_WAIT: if (m_cnt == STEP_M) begin
          m_cnt = 0; m_phase = P_READ; m_rd_en = 1'b1; m_addr = m_ptr;
        end
        P_READ: m_phase = P_SHIFT;
        P_SHIFT: begin
          m_win = {m_win[27:0], nib(m_addr)};
          m_shifted = 1'b1;
          if (m_ptr >= int'(bus.msg_len)) begin m_wrap = 1'b1; m_ptr = 0; end
          else m_ptr = m_ptr + 1;
          m_phase = P_WAIT;
        end
        default: ;
      endcase
    end
  end

  int          addr_q[$];
  logic [31:0] win_q[$];
  logic        wrap_q[$];

  // Every-cycle comparison plus capture of reads and shifts.
  always @(negedge clk) begin
    chk("rd_en",   32'(bus.rd_en),   32'(m_rd_en));
    chk("rd_addr", 32'(bus.rd_addr), 32'(m_addr));
    chk("window",  bus.window,       m_win);
    chk("shifted", 32'(bus.shifted), 32'(m_shifted));
    chk("wrap",    32'(bus.wrap),    32'(m_wrap));
    if (bus.rd_en) addr_q.push_back(int'(bus.rd_addr));
    if (bus.shifted) begin
      win_q.push_back(bus.window);
      wrap_q.push_back(bus.wrap);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int n, a0, s0;
  logic [31:0] exp_win[5] = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12341};
  int exp_addr[5] = '{0, 1, 2, 3, 0};
  logic exp_wrap[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int exp_after[4] = '{0, 1, 0, 1};

  initial begin
    reset = 1'b0; bus.start = 1'b0; bus.en = 1'b0; bus.msg_len = 6'd3;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("idle_no_read", 32'(addr_q.size()), 32'd0);
    chk("idle_window", bus.window, 32'h0);

    // Normal run over a 4-nibble message.
    bus.start = 1'b1; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 100 && win_q.size() < 5; i++) tick();
    chk("run_shift_count", 32'(win_q.size()), 32'd5);
    if (win_q.size() >= 5 && addr_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("run_window", win_q[i], exp_win[i]);
        chk("run_addr", 32'(addr_q[i]), 32'(exp_addr[i]));
        chk("run_wrap", 32'(wrap_q[i]), 32'(exp_wrap[i]));
      end
    end

    // Pause with the prescaler at 2, then resume.
    n = 0;
    while (n < 20 && !(m_phase == P_WAIT && m_cnt == 2)) begin tick(); n++; end
    chk("pause_point_found", 32'(n < 20), 32'd1);
    bus.en = 1'b0;
    a0 = addr_q.size();
    repeat (10) tick();
    chk("pause_no_read", 32'(addr_q.size() - a0), 32'd0);
    bus.en = 1'b1;
    n = 0;
    while (n < 10 && addr_q.size() == a0) begin tick(); n++; end
    chk("resume_latency", 32'(n), 32'd2);

    // start during READ discards the read.
    n = 0;
    while (n < 20 && m_phase != P_READ) begin tick(); n++; end
    s0 = win_q.size();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_read_window", bus.window, 32'h0);
    chk("start_read_shifted", 32'(bus.shifted), 32'd0);
    a0 = addr_q.size();
    for (int i = 0; i < 20 && addr_q.size() == a0; i++) tick();
    chk("start_first_addr", 32'(addr_q.size() > a0 ? addr_q[a0] : -1), 32'd0);
    chk("start_no_shift", 32'(win_q.size() - s0), 32'd0);

    // Shrink msg_len while address 3 is in flight.
    n = 0;
    while (n < 40 && !(m_phase == P_READ && m_addr == 3)) begin tick(); n++; end
    bus.msg_len = 6'd1;
    tick();
    tick();
    chk("shrink_shifted", 32'(bus.shifted), 32'd1);
    chk("shrink_wrap", 32'(bus.wrap), 32'd1);
    a0 = addr_q.size();
    for (int i = 0; i < 40 && addr_q.size() < a0 + 4; i++) tick();
    if (addr_q.size() >= a0 + 4)
      for (int i = 0; i < 4; i++) chk("shrink_addr", 32'(addr_q[a0+i]), 32'(exp_after[i]));
    else chk("shrink_read_count", 32'(addr_q.size() - a0), 32'd4);

    // Reset and start together in SHIFT: reset wins.
    n = 0;
    while (n < 20 && m_phase != P_SHIFT) begin tick(); n++; end
    reset = 1'b0; bus.start = 1'b1;
    tick();
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_window", bus.window, 32'h0);
    chk("rst_shifted", 32'(bus.shifted), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);
    reset = 1'b1; bus.start = 1'b0;
    a0 = addr_q.size();
    repeat (20) tick();
    chk("rst_idle_no_read", 32'(addr_q.size() - a0), 32'd0);

    // Single-nibble message: every step rereads address 0 and wraps.
    bus.msg_len = 6'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    s0 = win_q.size();
    for (int i = 0; i < 40 && win_q.size() < s0 + 3; i++) tick();
    if (win_q.size() >= s0 + 3) begin
      for (int i = 0; i < 3; i++) chk("len0_wrap", 32'(wrap_q[s0+i]), 32'd1);
      chk("len0_window", win_q[s0+2], 32'h111);
    end else chk("len0_shift_count", 32'(win_q.size() - s0), 32'd3);

    // Full-length message wraps from address 63 back to 0.
    bus.msg_len = 6'd63; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    s0 = win_q.size(); a0 = addr_q.size();
    for (int i = 0; i < 400 && win_q.size() < s0 + 65; i++) tick();
    if (win_q.size() >= s0 + 65 && addr_q.size() >= a0 + 65) begin
      chk("max_wrap_62", 32'(wrap_q[s0+62]), 32'd0);
      chk("max_wrap_63", 32'(wrap_q[s0+63]), 32'd1);
      chk("max_addr_63", 32'(addr_q[a0+63]), 32'd63);
      chk("max_addr_64", 32'(addr_q[a0+64]), 32'd0);
    end else chk("max_shift_count", 32'(win_q.size() - s0), 32'd65);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
